button_pulse_conditioner: RTL

Conditions two raw push-button inputs into clean, single-cycle control pulses for the lab 5 storage stage. Each button is synchronized, debounced, and edge-detected. The block emits a one-cycle clock-enable pulse and a one-cycle synchronous-reset pulse, which drive the `ce` and `reset` inputs of the D flip-flop with clock enable and synchronous reset. It also keeps an 8-bit count of accepted enable presses for display.

---
 rtl/lab5_pkg.sv | 13 +
 rtl/debounce_channel.sv | 89 ++++++++
 rtl/button_pulse_conditioner.sv | 51 +++++
 3 files changed

// File: rtl/lab5_pkg.sv
// Shared types and constants for the lab 5 button conditioning stage.
package lab5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, press/release debounce FSM and a
// registered single-cycle pulse on the first cycle of an accepted press.
module debounce_channel
  import lab5_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be at least 2");
  end

  logic             sync_1_reg;
  logic             sync_2_reg;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_reg;
  logic             pulse_next;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      pulse_reg  <= 1'b0;
    end else begin
      sync_1_reg <= btn_raw;
      sync_2_reg <= sync_1_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pulse_reg  <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sync_2_reg) begin
          state_next = ST_ARM;
          cnt_next   = '0;
        end
      end
      ST_ARM: begin
        if (!sync_2_reg) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ST_HELD;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync_2_reg) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end
      end
      ST_RELEASE: begin
        // Release bounce falls back to HELD silently, so one press gives one pulse.
        if (sync_2_reg) begin
          state_next = ST_HELD;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Two debounced button channels driving the downstream FF's ce and reset,
// with reset-wins collision gating and an 8-bit accepted-press counter.
module button_pulse_conditioner
  import lab5_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   btn_ce_raw,
  input  logic                   btn_rst_raw,
  output logic                   ce_pulse,
  output logic                   srst_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Channel 0 is the enable button, channel 1 the reset button.
  logic [1:0] btn_raw;
  logic [1:0] chan_pulse;

  assign btn_raw = {btn_rst_raw, btn_ce_raw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .Clk     (Clk),
      .reset_n (reset_n),
      .btn_raw (btn_raw[gi]),
      .pulse   (chan_pulse[gi])
    );
  end

  assign srst_pulse = chan_pulse[1];
  assign ce_pulse   = chan_pulse[0] & ~chan_pulse[1];

  logic [PRESS_CNT_W-1:0] press_count_reg;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      press_count_reg <= '0;
    end else if (srst_pulse) begin
      press_count_reg <= '0;
    end else if (ce_pulse) begin
      press_count_reg <= press_count_reg + 1'b1;
    end
  end

  assign press_count = press_count_reg;

endmodule
